// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the ID-stage hazard controller and the forwarding unit.
package hazard_control_unit_pkg;

    localparam int REG_ID_W = 16;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } id_ex_ctrl_t;

    // Control word ID/EX loads when bubbled: no architectural side effects.
    localparam id_ex_ctrl_t ID_EX_NOP = '0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle of the hazard controller: register ids in, stage enables and counters out.
interface hazard_control_unit_if #(
    parameter int REG_ID_W = hazard_control_unit_pkg::REG_ID_W,
    parameter int CNT_W    = 32
);
    logic                mem_read_ID_EX;
    logic [REG_ID_W-1:0] RegisterRD_ID_EX;
    logic [REG_ID_W-1:0] RS1_IF_ID;
    logic [REG_ID_W-1:0] RS2_IF_ID;
    logic                uses_rs1_IF_ID;
    logic                uses_rs2_IF_ID;
    logic                branch_taken_EX;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic [CNT_W-1:0]    stall_count;
    logic [CNT_W-1:0]    flush_count;

    modport master (
        output mem_read_ID_EX, RegisterRD_ID_EX, RS1_IF_ID, RS2_IF_ID,
               uses_rs1_IF_ID, uses_rs2_IF_ID, branch_taken_EX,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               stall_count, flush_count
    );

    modport slave (
        input  mem_read_ID_EX, RegisterRD_ID_EX, RS1_IF_ID, RS2_IF_ID,
               uses_rs1_IF_ID, uses_rs2_IF_ID, branch_taken_EX,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               stall_count, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects inc one edge later; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-redirect flush controller for the ID stage, with perf counters.
// Latency: controls are combinational (0 cycles); the stall itself is the backpressure on IF/ID.
module hazard_control_unit #(
    parameter int REG_ID_W     = hazard_control_unit_pkg::REG_ID_W,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hcu
);
    import hazard_control_unit_pkg::*;

    localparam logic [2:0] REMAIN_INIT = 3'(STALL_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          remain_q, remain_d;
    logic [REG_ID_W-1:0] rd;
    logic                hazard;
    logic                stall_inc;
    logic                flush_inc;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;

    assign rd = hcu.RegisterRD_ID_EX;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = hcu.mem_read_ID_EX && (rd != '0) &&
                    ((hcu.uses_rs1_IF_ID && (rd == hcu.RS1_IF_ID)) ||
                     (hcu.uses_rs2_IF_ID && (rd == hcu.RS2_IF_ID)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hcu.branch_taken_EX) begin
            // A redirect wins over any hazard and aborts a stall in progress.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            state_d      = RUN;
            remain_d     = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d  = STALL;
                            remain_d = REMAIN_INIT;
                        end
                    end
                end
                STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_inc    = 1'b1;
                    remain_d     = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = RUN;
                    remain_d = '0;
                end
            endcase
        end
    end

    assign hcu.pc_write     = pc_write;
    assign hcu.if_id_write  = if_id_write;
    assign hcu.if_id_flush  = if_id_flush;
    assign hcu.id_ex_bubble = id_ex_bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (hcu.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (hcu.flush_count)
    );

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller in the ID stage of the 5-stage core; it is the upstream companion of the forwarding unit. It detects load-use hazards that forwarding cannot resolve and holds PC and IF/ID while bubbling ID/EX for a configurable number of cycles. It flushes the front end when a branch or jump resolves taken in EX. It also keeps saturating stall and flush event counters for performance reporting.

## Interface
Parameters:
- REG_ID_W, 16, width of register identifiers; matches the forwarding unit's RS/RD ports.
- STALL_CYCLES, 1, number of bubble cycles per load-use hazard; legal range 1..7.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_ID_EX  in  1  the instruction in EX (ID/EX register) is a load.
- RegisterRD_ID_EX  in  REG_ID_W  destination of the instruction in EX.
- RS1_IF_ID  in  REG_ID_W  rs1 of the instruction in ID.
- RS2_IF_ID  in  REG_ID_W  rs2 of the instruction in ID.
- uses_rs1_IF_ID  in  1  the ID instruction reads rs1.
- uses_rs2_IF_ID  in  1  the ID instruction reads rs2.
- branch_taken_EX  in  1  a branch or jump in EX redirects the PC this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID clears to NOP on the next edge.
- id_ex_bubble  out  1  ID/EX loads NOP controls (reg_write=0, mem_read=0) on the next edge.
- stall_count  out  CNT_W  total stall cycles since reset, saturating.
- flush_count  out  CNT_W  total taken-redirect flushes since reset, saturating.

## Operation
- The block is a Mealy FSM with two states: RUN and STALL. It also holds a 3-bit down-counter `remain`.
- hazard = mem_read_ID_EX && RegisterRD_ID_EX != 0 && ((uses_rs1_IF_ID && RegisterRD_ID_EX == RS1_IF_ID) || (uses_rs2_IF_ID && RegisterRD_ID_EX == RS2_IF_ID)).
- Default outputs: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- RUN, branch_taken_EX=1:
  - Outputs: if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - flush_count increments. State stays RUN.
  - branch_taken_EX has priority over hazard.
- RUN, hazard=1, no branch:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - stall_count increments.
  - If STALL_CYCLES=1, state stays RUN. Otherwise state goes to STALL with remain=STALL_CYCLES-1.
- STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1. stall_count increments.
  - remain decrements each cycle. When remain==1, state goes to RUN on this edge.
  - The hazard input is ignored in STALL.
- STALL, branch_taken_EX=1: this is illegal in normal flow because EX holds a bubble. If it occurs anyway:
  - The flush behaviour of RUN applies and flush_count increments.
  - The stall is aborted, state goes to RUN, and stall_count does not increment that cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Control outputs are combinational from state and inputs, with zero-cycle latency. Downstream registers act on the next rising edge.
- One load-use hazard produces exactly STALL_CYCLES consecutive cycles with pc_write=0.
  - The ID instruction re-evaluates in RUN on the following cycle.
  - By then the load has advanced, so the forwarding unit resolves it.
- A taken redirect produces exactly one cycle of if_id_flush=1 and id_ex_bubble=1.
- Reset, sampled on the edge:
  - state=RUN, remain=0, stall_count=0, flush_count=0.
  - While rst=1, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
- Reset mid-STALL aborts the stall immediately. The first cycle after rst deasserts is RUN with default outputs, unless a hazard or branch is present that cycle.

## Structure
- A shared package holds:
  - the state typedef (RUN, STALL);
  - the NOP control constant used by ID/EX bubbling;
  - REG_ID_W, which the forwarding unit also uses.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice for stall_count and flush_count.

## Test plan
- Load x5 in EX, ID instruction add with rs1=5, STALL_CYCLES=1 → exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1; RUN the next cycle.
- STALL_CYCLES=3, load x7 in EX, ID rs2=7 with uses_rs2=1 → three consecutive stall cycles; stall_count=3. Same case with uses_rs2=0 → no stall.
- Load x0 in EX, ID rs1=0 → no stall. RegisterRD=x0 is never a hazard.
- branch_taken_EX=1 in the same cycle as hazard=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall; flush_count=1, stall_count=0.
- STALL_CYCLES=4, assert rst in the second stall cycle → next cycle state=RUN, both counters 0, pc_write=1 after rst deasserts.
- CNT_W=4, force 20 back-to-back hazards → stall_count holds at 15 and never wraps to 0.
